// File: rtl/load_access_sequencer.sv
// Sequences one MIPS big-endian load (lb/lbu/lh/lhu/lw/lwl/lwr) through a req/ack
// data memory and presents an aligned, merged register write with byte enables.
module load_access_sequencer #(
  parameter int TO_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [3:0]  ld_op,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_rt_old,
  input  logic [4:0]  ld_dest,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic [3:0]  wb_be,
  output logic        addr_err,
  output logic        bus_err,
  output logic        busy
);

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LBU = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LWL = 4'b0011;
  localparam logic [3:0] OP_LH  = 4'b0100;
  localparam logic [3:0] OP_LWR = 4'b0101;
  localparam logic [3:0] OP_LHU = 4'b0110;

  // Last count value seen before the wait turns into a timeout: 2^TO_W-1 wait cycles total.
  localparam logic [TO_W-1:0] CNT_LAST = TO_W'((2 ** TO_W) - 2);

  typedef enum logic [2:0] {IDLE, WAIT, WB, DRAIN, ERR} state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] rt_old;
    logic [4:0]  dest;
  } ld_req_t;

  state_t          state_q, state_d;
  ld_req_t         req_q;
  logic [TO_W-1:0] cnt_q;
  logic [4:0]      wb_dest_q;
  logic [31:0]     wb_data_q;
  logic [3:0]      wb_be_q;
  logic            bus_err_q;

  logic        accept, legal, misal, waiting, timeout;
  logic [1:0]  k;
  logic [4:0]  sh_l, sh_r;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] algn_data;
  logic [3:0]  algn_be;

  assign ld_ready = (state_q == IDLE) && !flush;
  assign accept   = ld_valid && ld_ready;
  assign legal    = ld_op < 4'd7;
  assign misal    = (((ld_op == OP_LH) || (ld_op == OP_LHU)) && ld_addr[0]) ||
                    ((ld_op == OP_LW) && (ld_addr[1:0] != 2'b00));
  assign waiting  = (state_q == WAIT) || (state_q == DRAIN);
  assign timeout  = waiting && !mem_ack && (cnt_q == CNT_LAST);

  assign mem_req  = waiting;
  assign mem_addr = waiting ? {req_q.addr[31:2], 2'b00} : 32'h0;
  assign wb_valid = (state_q == WB);
  assign wb_dest  = wb_valid ? wb_dest_q : 5'h0;
  assign wb_data  = wb_valid ? wb_data_q : 32'h0;
  assign wb_be    = wb_valid ? wb_be_q   : 4'h0;
  assign addr_err = (state_q == ERR);
  assign bus_err  = bus_err_q;
  assign busy     = (state_q != IDLE);

  // Byte 0 lives in bits 31:24, so byte k sits at bit offset 8*(3-k).
  always_comb begin
    k         = req_q.addr[1:0];
    sh_l      = {k, 3'b000};
    sh_r      = {~k, 3'b000};
    byte_v    = mem_rdata[sh_r +: 8];
    half_v    = (k == 2'b00) ? mem_rdata[31:16] : mem_rdata[15:0];
    algn_data = mem_rdata;
    algn_be   = 4'hF;
    case (req_q.op)
      OP_LB:  algn_data = {{24{byte_v[7]}}, byte_v};
      OP_LBU: algn_data = {24'h0, byte_v};
      OP_LH:  algn_data = {{16{half_v[15]}}, half_v};
      OP_LHU: algn_data = {16'h0, half_v};
      OP_LWL: begin
        algn_data = (mem_rdata << sh_l) | (req_q.rt_old & ~(32'hFFFF_FFFF << sh_l));
        algn_be   = 4'(4'b1111 << k);
      end
      OP_LWR: begin
        algn_data = (mem_rdata >> sh_r) | (req_q.rt_old & ~(32'hFFFF_FFFF >> sh_r));
        algn_be   = 4'(4'b1111 >> (~k));
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = !legal ? IDLE : (misal ? ERR : WAIT);
      WAIT: begin
        if (mem_ack)      state_d = flush ? IDLE : WB;
        else if (timeout) state_d = IDLE;
        else if (flush)   state_d = DRAIN;
      end
      DRAIN: if (mem_ack || timeout) state_d = IDLE;
      WB:    state_d = IDLE;
      ERR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      cnt_q     <= '0;
      wb_dest_q <= '0;
      wb_data_q <= '0;
      wb_be_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= timeout;
      if (accept) begin
        req_q <= '{op: ld_op, addr: ld_addr, rt_old: ld_rt_old, dest: ld_dest};
        cnt_q <= '0;
      end else if (waiting && !mem_ack) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if ((state_q == WAIT) && mem_ack && !flush) begin
        wb_dest_q <= req_q.dest;
        wb_data_q <= algn_data;
        wb_be_q   <= algn_be;
      end
    end
  end

endmodule

// File: doc/load_access_sequencer.md
Name: load_access_sequencer

Overview:
- Multi-cycle controller that sequences one load instruction from the MEM stage through a word-wide data memory with a req/ack handshake.
- Aligns, extends and merges the returned word for the MIPS big-endian load family: lb, lbu, lh, lhu, lw, lwl, lwr.
- Presents a single-cycle register-file write with per-byte write enables to the writeback stage.
- Also raises address-error and bus-timeout pulses, and handles pipeline flush.

Parameters:
TO_W, 8, width of the memory-wait timeout counter; timeout fires after 2^TO_W - 1 wait cycles without mem_ack.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
ld_valid  in  1  load request present
ld_ready  out  1  sequencer can accept (IDLE and not flush)
ld_op  in  4  0000 lb, 0001 lbu, 0010 lw, 0011 lwl, 0100 lh, 0101 lwr, 0110 lhu; others illegal
ld_addr  in  32  effective byte address
ld_rt_old  in  32  current rt value (merge source for lwl/lwr)
ld_dest  in  5  destination register number
flush  in  1  pipeline flush; abandons the in-flight load
mem_req  out  1  memory read request, held until mem_ack
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_ack  in  1  memory read data valid this cycle
mem_rdata  in  32  memory read word; byte 0 = bits 31:24
wb_valid  out  1  register write strobe, one cycle
wb_dest  out  5  register number
wb_data  out  32  aligned/merged data
wb_be  out  4  byte write enables, bit3 = bits 31:24
addr_err  out  1  one-cycle pulse: misaligned lh/lhu/lw
bus_err  out  1  one-cycle pulse: memory timeout
busy  out  1  state != IDLE

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE; all outputs 0 except ld_ready = 1 (when flush = 0); timeout counter 0.
- FSM states: IDLE, WAIT, WB, DRAIN, ERR.
- IDLE:
  - Accept when ld_valid && ld_ready; latch op, addr, rt_old, dest.
  - Illegal op: return to IDLE with no memory access and no writeback.
  - Misaligned access (lh/lhu with addr[0] = 1, or lw with addr[1:0] != 0): go to ERR.
  - Otherwise go to WAIT.
- ERR: addr_err = 1 for one cycle, then IDLE.
- WAIT:
  - mem_req = 1, mem_addr stable, counter increments each cycle.
  - mem_ack: capture the result into the wb registers; go to WB.
  - flush without ack: go to DRAIN.
  - flush with ack in the same cycle: discard the result; go to IDLE.
  - Counter reaching 2^TO_W - 1 without ack: bus_err pulse next cycle; go to IDLE; mem_req drops.
- DRAIN: mem_req stays 1 until mem_ack (no outstanding read is abandoned); data is discarded, then IDLE. Timeout applies identically.
- WB: wb_valid = 1 for exactly one cycle, then IDLE. flush during WB has no effect (already committed).
- Latency: acceptance edge N with mem_ack in the first WAIT cycle gives wb_valid during cycle N+2. Back-to-back loads need at least 3 cycles each.
- Data rules, k = addr[1:0], B(i) = mem_rdata[31-8i -: 8]:
  - lb/lbu: wb_data = sign/zero-extended B(k); be = 1111.
  - lh/lhu: half = k==0 ? rdata[31:16] : rdata[15:0]; extend; be = 1111.
  - lw: wb_data = rdata; be = 1111.
  - lwl: wb_data = (rdata << 8k) | (rt_old & ~(32'hFFFFFFFF << 8k)); be: k0 1111, k1 1110, k2 1100, k3 1000.
  - lwr: wb_data = (rdata >> 8(3-k)) | (rt_old & ~(32'hFFFFFFFF >> 8(3-k))); be: k0 0001, k1 0011, k2 0111, k3 1111.
  - wb_data is fully merged, so bytes outside be already equal rt_old.
- Flush vs. ld_valid in the same IDLE cycle: flush wins; nothing is accepted.
- Reset mid-operation: immediate return to IDLE, all outputs cleared, no write issued.

Test Plan:
1. lb at addr 0x1003, rdata 0x112233F0, ack in the first WAIT cycle -> wb_valid at N+2, wb_data 0xFFFFFFF0, be 1111; lbu gives 0x000000F0.
2. lwl at addr 0x2001, rdata 0xAABBCCDD, rt_old 0x11223344 -> wb_data 0xBBCCDD44, be 1110. lwr at addr 0x2001, same data -> wb_data 0x1122AABB, be 0011.
3. lh at addr 0x3001 -> addr_err pulse one cycle, mem_req never asserted, no wb_valid, ld_ready back at 1 two cycles after acceptance.
4. lw accepted, flush asserted in WAIT, mem_ack 5 cycles later -> mem_req held through ack, no wb_valid, busy drops the cycle after ack.
5. lw with mem_ack never asserted, TO_W = 4 -> bus_err pulse after 15 wait cycles, mem_req deasserts, ld_ready = 1 the next cycle.
6. rst_n pulled low during WAIT -> all outputs 0 asynchronously, ld_ready = 1 after release, and the next lhu at 0x4002 with rdata 0x0000BEEF gives wb_data 0x0000BEEF.
